// File: rtl/reg_wb_arb.sv
// Write-back arbiter: shares the register-file write port between
// NUM_SRC requesters with round-robin grant and a registered write.
// Ports: clk, rst (async active-high); src_valid/src_addr/src_data in,
// src_ready out (one-hot grant); wb_hold in; wb_en/wb_addr/wb_data/wb_src
// registered write to the register file; busy.
// Optional macro WB_FIXED_PRIO_EN: lowest valid index always wins and
// the round-robin pointer is removed.
module reg_wb_arb #(
    parameter int NUM_SRC = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      wb_hold,
    output logic                      wb_en,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic [1:0]                wb_src,
    output logic                      busy
);

    logic              w_found;
    logic [1:0]        w_gidx;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

`ifdef WB_FIXED_PRIO_EN
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && src_valid[i]) begin
                w_found = 1'b1;
                w_gidx  = 2'(i);
            end
        end
    end
`else
    logic [1:0] r_rr_ptr;
    int         w_best;
    int         w_dist;

    // Pick the valid source closest to r_rr_ptr going upward with wrap.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_best  = NUM_SRC;
        w_dist  = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i >= int'(r_rr_ptr)) w_dist = i - int'(r_rr_ptr);
            else                     w_dist = i + NUM_SRC - int'(r_rr_ptr);
            if (src_valid[i] && w_dist < w_best) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_gidx  = 2'(i);
            end
        end
    end
`endif

    // Grant is suppressed during reset and pipeline hold.
    assign w_xfer    = w_found && !wb_hold && !rst;
    assign src_ready = w_xfer ? (NUM_SRC'(1) << w_gidx) : '0;
    assign w_addr    = src_addr[w_gidx*ADDR_W +: ADDR_W];
    assign w_data    = src_data[w_gidx*DATA_W +: DATA_W];
    assign busy      = (|src_valid) || wb_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_src  <= '0;
        end else begin
            wb_en <= w_xfer;
            if (w_xfer) begin
                wb_addr <= w_addr;
                wb_data <= w_data;
                wb_src  <= w_gidx;
            end
        end
    end

`ifndef WB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            if (int'(w_gidx) == NUM_SRC - 1) r_rr_ptr <= '0;
            else                             r_rr_ptr <= w_gidx + 2'd1;
        end
    end
`endif

endmodule
